// File: rtl/display_pkg.sv
// display_pkg
// Constants shared by the pushbutton counter and the 7-segment display
// converter. Both stages must agree on the count width, its ceiling and the
// electrical level of a pressed key.
//   NUM_W            width of the displayed number
//   NUM_MAX          largest displayable count
//   KEY_PRESSED      level of a pressed (active-low) pushbutton
//   DEBOUNCE_DEFAULT stable cycles needed to accept a key change (20 ms @ 50 MHz)
package display_pkg;

  localparam int NUM_W = 4;
  localparam logic [NUM_W-1:0] NUM_MAX = 4'd15;
  localparam logic KEY_PRESSED = 1'b0;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef logic [NUM_W-1:0] num_t;

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
// Turns one raw, bouncing, active-low pushbutton into a single-cycle press
// pulse: two-flop synchroniser, stable-level debounce counter and a 1->0
// edge detector on the debounced level.
// Optional feature macro: BUTTON_COUNTER_AUTOREPEAT_EN adds a per-key repeat
// timer that emits further press pulses while the key stays held.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   key_n  raw asynchronous button level, 0 = pressed
//   press  one-cycle pulse per accepted press (and per repeat when enabled)
module key_debouncer
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          state;
  logic          state_d;
  logic [CW-1:0] cnt;
  logic          edge_evt;

  // Synchroniser -> debounce -> edge register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      state   <= 1'b1;
      state_d <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      state_d <= state;
      // The counter only runs while the synced level disagrees with the
      // accepted level, so any bounce back restarts it from zero.
      if (sync_p1 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign edge_evt = (state_d != KEY_PRESSED) && (state == KEY_PRESSED);

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          held;
  logic          rep_phase;
  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // Held means pressed for at least one cycle beyond the initial press edge,
  // so the timer starts counting on the cycle after the first event.
  assign held     = (state == KEY_PRESSED) && (state_d == KEY_PRESSED);
  assign rep_fire = held && (rep_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST));

  // Repeat timer: first wait REPEAT_DELAY, then REPEAT_PERIOD per repeat
  always_ff @(posedge clk) begin
    if (!rst_n || !held) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign press = edge_evt || rep_fire;
`else
  assign press = edge_evt;
`endif

endmodule

// File: rtl/button_counter.sv
// button_counter
// Up/down counter driven by two debounced pushbuttons; its output feeds the
// 7-segment display converter.
// Optional feature macro: BUTTON_COUNTER_AUTOREPEAT_EN (held keys repeat).
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   key_inc_n  raw increment button, 0 = pressed
//   key_dec_n  raw decrement button, 0 = pressed
//   number     registered count 0..15
//   changed    one-cycle pulse on the cycle after number took a new value
module button_counter
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int WRAP            = 1,
  parameter int INIT_VALUE      = 0
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_inc_n,
  input  logic             key_dec_n,
  output logic [NUM_W-1:0] number,
  output logic             changed
);

  localparam num_t INIT_NUM = num_t'(INIT_VALUE);

  logic inc_evt;
  logic dec_evt;
  num_t nxt;
  logic upd;
  logic upd_p0;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_inc_n),
    .press (inc_evt)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_dec_n),
    .press (dec_evt)
  );

  // Opposing events in the same cycle cancel. A saturated step is not an
  // update, so it never raises changed.
  always_comb begin
    nxt = number;
    upd = 1'b0;
    if (inc_evt && !dec_evt) begin
      if (number == NUM_MAX) begin
        if (WRAP != 0) begin
          nxt = '0;
          upd = 1'b1;
        end
      end else begin
        nxt = number + num_t'(1);
        upd = 1'b1;
      end
    end else if (dec_evt && !inc_evt) begin
      if (number == '0) begin
        if (WRAP != 0) begin
          nxt = NUM_MAX;
          upd = 1'b1;
        end
      end else begin
        nxt = number - num_t'(1);
        upd = 1'b1;
      end
    end
  end

  // Count register; changed trails the update by one more edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      number  <= INIT_NUM;
      upd_p0  <= 1'b0;
      changed <= 1'b0;
    end else begin
      number  <= nxt;
      upd_p0  <= upd;
      changed <= upd_p0;
    end
  end

endmodule
